// File: rtl/digit_serial_mag_comp.sv
// digit_serial_mag_comp
//
// Multi-cycle magnitude comparator. A captured operand pair is examined
// one DIGIT-bit slice per cycle, starting at the most significant slice.
// The comparison stops at the first slice where the operands differ, or
// after the least significant slice when they are equal. The result is
// returned as a one-hot lt/eq/gt triple, together with the number of
// slices that were examined.
//
// Parameters:
//   WIDTH  operand width in bits (>= 1)
//   DIGIT  bits compared per cycle (1 <= DIGIT <= WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair offered
//   in_ready   block can accept a pair (asserted only in IDLE)
//   a, b       operands, sampled only at acceptance
//   out_valid  result available (asserted only in DONE)
//   out_ready  consumer takes the result
//   lt/eq/gt   one-hot ordering of A relative to B, held while out_valid
//   ncmp       number of slices examined, 1..NDIG
//
// Build option:
//   DIGIT_SERIAL_MAG_COMP_SIGNED_EN  two's-complement compare. Operands are
//   sign-extended at capture and the top bit is inverted (offset binary),
//   so the plain unsigned slice compare yields the signed order.

module digit_serial_mag_comp #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4,
    localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT,
    localparam int CW   = $clog2(NDIG + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [CW-1:0]    ncmp
);

    // Extended operand width and slice-index width.
    localparam int EW = NDIG * DIGIT;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Operands are kept in left-shifting registers: the slice under test is
    // always the top DIGIT bits, which avoids a variable-index slice mux.
    logic [EW-1:0]    a_sh;
    logic [EW-1:0]    b_sh;
    logic [EW-1:0]    a_ext;
    logic [EW-1:0]    b_ext;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    count;
    logic [DIGIT-1:0] a_top;
    logic [DIGIT-1:0] b_top;
    logic             slice_diff;
    logic             last_slice;
    logic             accept;

    // ------------------------------------------------------------------
    // Operand extension at capture
    // ------------------------------------------------------------------
    always_comb begin
`ifdef DIGIT_SERIAL_MAG_COMP_SIGNED_EN
        a_ext = EW'($signed(a));
        b_ext = EW'($signed(b));
        // Offset-binary: flipping the sign bit maps signed order onto
        // unsigned order. Padding bits above WIDTH are copies of the sign,
        // so after the flip they still cannot favour either operand wrongly.
        a_ext[EW-1] = ~a_ext[EW-1];
        b_ext[EW-1] = ~b_ext[EW-1];
`else
        a_ext = EW'(a);
        b_ext = EW'(b);
`endif
    end

    // ------------------------------------------------------------------
    // Slice compare
    // ------------------------------------------------------------------
    assign a_top      = a_sh[EW-1 -: DIGIT];
    assign b_top      = b_sh[EW-1 -: DIGIT];
    assign slice_diff = (a_top != b_top);
    assign last_slice = (idx == '0);
    assign accept     = in_valid & in_ready;

    // Handshake outputs are pure state decodes.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (slice_diff || last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            idx   <= '0;
            count <= '0;
            lt    <= 1'b0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            ncmp  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= a_ext;
                        b_sh  <= b_ext;
                        idx   <= IW'(NDIG - 1);
                        count <= '0;
                    end
                end
                RUN: begin
                    count <= count + CW'(1);
                    if (slice_diff) begin
                        lt   <= (a_top < b_top);
                        gt   <= (a_top > b_top);
                        ncmp <= count + CW'(1);
                    end else if (last_slice) begin
                        eq   <= 1'b1;
                        ncmp <= count + CW'(1);
                    end else begin
                        idx  <= idx - IW'(1);
                        a_sh <= a_sh << DIGIT;
                        b_sh <= b_sh << DIGIT;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        lt   <= 1'b0;
                        eq   <= 1'b0;
                        gt   <= 1'b0;
                        ncmp <= '0;
                    end
                end
                default: begin
                    lt   <= 1'b0;
                    eq   <= 1'b0;
                    gt   <= 1'b0;
                    ncmp <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_mag_comp.sv
// Bench for digit_serial_mag_comp: a 16/4 instance and a 10/4 instance
// share the clock, reset and handshake drivers; sel picks the active one.

module tb_digit_serial_mag_comp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a16, b16;
    logic [9:0]  a10, b10;

    logic        in_ready16, out_valid16, lt16, eq16, gt16;
    logic [2:0]  ncmp16;
    logic        in_ready10, out_valid10, lt10, eq10, gt10;
    logic [1:0]  ncmp10;

    logic        in_ready_o, out_valid_o, lt_o, eq_o, gt_o;
    int          ncmp_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    digit_serial_mag_comp #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid & ~sel),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .out_valid (out_valid16),
        .out_ready (out_ready & ~sel),
        .lt        (lt16),
        .eq        (eq16),
        .gt        (gt16),
        .ncmp      (ncmp16)
    );

    digit_serial_mag_comp #(.WIDTH(10), .DIGIT(4)) u_dut10 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid & sel),
        .in_ready  (in_ready10),
        .a         (a10),
        .b         (b10),
        .out_valid (out_valid10),
        .out_ready (out_ready & sel),
        .lt        (lt10),
        .eq        (eq10),
        .gt        (gt10),
        .ncmp      (ncmp10)
    );

    always_comb begin
        in_ready_o  = sel ? in_ready10  : in_ready16;
        out_valid_o = sel ? out_valid10 : out_valid16;
        lt_o        = sel ? lt10 : lt16;
        eq_o        = sel ? eq10 : eq16;
        gt_o        = sel ? gt10 : gt16;
        ncmp_o      = sel ? int'(ncmp10) : int'(ncmp16);
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: ordering from integer arithmetic on the operand values;
    // slices examined from the highest differing bit of the extended operands.
    function automatic void model(input int w, input longint unsigned av,
                                  input longint unsigned bv,
                                  output bit elt, output bit eeq, output bit egt,
                                  output int enc);
        int nd = (w + 3) / 4;
        int ew = nd * 4;
        longint sa = longint'(av);
        longint sb = longint'(bv);
        longint unsigned xa, xb, x;
        int top = -1;
`ifdef DIGIT_SERIAL_MAG_COMP_SIGNED_EN
        if (av >= (64'd1 << (w - 1))) sa = sa - (64'sd1 << w);
        if (bv >= (64'd1 << (w - 1))) sb = sb - (64'sd1 << w);
`endif
        elt = (sa < sb);
        eeq = (sa == sb);
        egt = (sa > sb);
        xa = sa;
        xb = sb;
        x = (xa ^ xb) & ((64'd1 << ew) - 1);
        for (int i = 0; i < ew; i++) if (x[i]) top = i;
        enc = (top < 0) ? nd : nd - top / 4;
    endfunction

    task automatic do_op(input bit s, input longint unsigned av,
                         input longint unsigned bv, input int hold);
        bit elt, eeq, egt;
        int enc;
        int w = s ? 10 : 16;
        int lat;
        model(w, av, bv, elt, eeq, egt, enc);
        @(negedge clk);
        sel = s;
        if (s) begin a10 = av[9:0];  b10 = bv[9:0];  end
        else   begin a16 = av[15:0]; b16 = bv[15:0]; end
        out_ready = 1'b0;
        #1;
        check("idle_in_ready", in_ready_o, 1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Operands must have been sampled only at acceptance.
        a16 = 16'($urandom); b16 = 16'($urandom);
        a10 = 10'($urandom); b10 = 10'($urandom);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid_o) break;
        end
        check("latency", lat, enc);
        check("lt", lt_o, elt);
        check("eq", eq_o, eeq);
        check("gt", gt_o, egt);
        check("ncmp", ncmp_o, enc);
        check("done_in_ready", in_ready_o, 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("hold_valid", out_valid_o, 1);
            check("hold_in_ready", in_ready_o, 0);
            check("hold_res", {lt_o, eq_o, gt_o}, {elt, eeq, egt});
            check("hold_ncmp", ncmp_o, enc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_valid", out_valid_o, 0);
        check("post_res", {lt_o, eq_o, gt_o, 3'(ncmp_o)}, 0);
        check("post_in_ready", in_ready_o, 1);
    endtask

    initial begin
        bit seen;
        longint unsigned ra, rb;
        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a16 = '0; b16 = '0; a10 = '0; b10 = '0;
        #12;
        check("rst_in_ready", in_ready_o, 1);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_res", {lt_o, eq_o, gt_o, 3'(ncmp_o)}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(0, 64'h1234, 64'h1234, 0);
        do_op(0, 64'h8000, 64'h7FFF, 0);
        do_op(0, 64'h00A5, 64'h00A6, 0);
        do_op(0, 64'h0F00, 64'h0E00, 5);
        do_op(1, 64'h3FF,  64'h3FE,  0);
        do_op(1, 64'h200,  64'h1FF,  2);
        do_op(1, 64'h155,  64'h155,  1);

        for (int n = 0; n < 60; n++) begin
            bit s = n[0];
            int w = s ? 10 : 16;
            longint unsigned m = (64'd1 << w) - 1;
            ra = longint'($urandom) & m;
            case ($urandom_range(0, 3))
                0:       rb = longint'($urandom) & m;
                1:       rb = ra;
                default: rb = ra ^ (64'd1 << $urandom_range(0, w - 1));
            endcase
            do_op(s, ra, rb, int'($urandom_range(0, 3)));
        end

        // Reset during the second RUN cycle.
        @(negedge clk);
        sel = 1'b0; a16 = 16'h0001; b16 = 16'h0002; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 check("run_in_ready", in_ready_o, 0);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid_o, 0);
        check("arst_in_ready", in_ready_o, 1);
        check("arst_res", {lt_o, eq_o, gt_o, 3'(ncmp_o)}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid_o) seen = 1'b1;
        end
        check("arst_no_result", seen, 0);
        out_ready = 1'b0;

        do_op(0, 64'hFFFF, 64'h0000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
